// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial subtraction
// through a generate/propagate carry chain, start/done handshake.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one restoring iteration per cycle
    // S_DONE | results valid, done pulse
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_a;
    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_g;
    logic [WIDTH:0]   w_p;
    logic [WIDTH+1:0] w_c;
    logic [WIDTH:0]   w_t;
    logic             w_no_borrow;
    logic [WIDTH:0]   w_r_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_count == LAST);

    // Shifted partial remainder minus {0,D}, computed as a + ~b + 1.
    assign w_a = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_b = ~{1'b0, r_d};
    assign w_g = w_a & w_b;
    assign w_p = w_a ^ w_b;

    always_comb begin
        w_c    = '0;
        w_c[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign w_t         = w_p ^ w_c[WIDTH:0];
    assign w_no_borrow = w_c[WIDTH+1];
    assign w_r_nxt     = w_no_borrow ? w_t : w_a;
    assign w_q_nxt     = {r_q[WIDTH-2:0], w_no_borrow};

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_count <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dbz <= w_div_zero;
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                        end else begin
                            r_q     <= dividend;
                            r_d     <= divisor;
                            r_r     <= '0;
                            r_count <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_q     <= w_q_nxt;
                    r_r     <= w_r_nxt;
                    r_count <= r_count + CW'(1);
                    // Results are published on the final iteration so they are valid with done.
                    if (w_last) begin
                        r_quot <= w_q_nxt;
                        r_rem  <= w_r_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
